// File: rtl/ngv_rgb_fader.sv
// ngv_rgb_fader: crossfading PWM driver for an RGB LED.
// Takes the step sequencer's active-low one-hot colour selects and ramps
// each channel's duty toward its goal (full or off), one step per STEP_DIV
// clocks. The duty is latched at each PWM period boundary, so the LED only
// ever shows complete periods.
// Ports:
//   clk              system clock
//   rst              synchronous reset, active-high
//   sel_r/g/b_n      colour selects from the sequencer, active-low
//   led_r/g/b        LED drives, active-low PWM, registered
//   busy             high while a fade is in progress
module ngv_rgb_fader #(
   parameter int unsigned PWM_W    = 8,
   parameter int unsigned STEP_DIV = 46875
) (
   input  logic clk,
   input  logic rst,
   input  logic sel_r_n,
   input  logic sel_g_n,
   input  logic sel_b_n,
   output logic led_r,
   output logic led_g,
   output logic led_b,
   output logic busy
);

   localparam int unsigned PRE_W = $clog2(STEP_DIV);
   localparam logic [PWM_W-1:0] MAX = {PWM_W{1'b1}};
   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(STEP_DIV - 1);

   typedef enum logic {IDLE, FADE} state_t;

   state_t           state;
   logic [2:0]       sel_q;
   logic [2:0]       target;   // {b,g,r}, at most one bit set
   logic [PRE_W-1:0] pre;
   logic [PWM_W-1:0] pwm_cnt;
   logic [PWM_W-1:0] duty_r, duty_g, duty_b;
   logic [PWM_W-1:0] lat_r, lat_g, lat_b;

   // One duty step toward the goal; goals are only 0 or MAX, so the
   // end-stop test doubles as saturation.
   function automatic logic [PWM_W-1:0] ramp(input logic [PWM_W-1:0] d, input logic up);
      logic [PWM_W-1:0] r;
      r = d;
      if (up && (d != MAX))
         r = d + PWM_W'(1);
      else if (!up && (d != '0))
         r = d - PWM_W'(1);
      return r;
   endfunction

   logic [PWM_W-1:0] goal_r, goal_g, goal_b;
   logic [PWM_W-1:0] nxt_r, nxt_g, nxt_b;
   logic             at_goal, nxt_at_goal, tick;
   logic             on_r, on_g, on_b;

   // Goals, next-step duties and PWM compare.
   always_comb begin
      goal_r      = target[0] ? MAX : '0;
      goal_g      = target[1] ? MAX : '0;
      goal_b      = target[2] ? MAX : '0;
      nxt_r       = ramp(duty_r, target[0]);
      nxt_g       = ramp(duty_g, target[1]);
      nxt_b       = ramp(duty_b, target[2]);
      at_goal     = (duty_r == goal_r) && (duty_g == goal_g) && (duty_b == goal_b);
      nxt_at_goal = (nxt_r == goal_r) && (nxt_g == goal_g) && (nxt_b == goal_b);
      tick        = (state == FADE) && (pre == PRE_LAST);
      on_r        = (lat_r == MAX) || (pwm_cnt < lat_r);
      on_g        = (lat_g == MAX) || (pwm_cnt < lat_g);
      on_b        = (lat_b == MAX) || (pwm_cnt < lat_b);
   end

   // Input stage, target decode, fade FSM and PWM output.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         busy    <= 1'b0;
         sel_q   <= '0;
         target  <= '0;
         pre     <= '0;
         pwm_cnt <= '0;
         duty_r  <= '0;
         duty_g  <= '0;
         duty_b  <= '0;
         lat_r   <= '0;
         lat_g   <= '0;
         lat_b   <= '0;
         led_r   <= 1'b1;
         led_g   <= 1'b1;
         led_b   <= 1'b1;
      end else begin
         sel_q <= ~{sel_b_n, sel_g_n, sel_r_n};

         // Multi-select is treated as a sequencer glitch: keep the old target.
         case (sel_q)
            3'b000, 3'b001, 3'b010, 3'b100: target <= sel_q;
            default:                        target <= target;
         endcase

         pwm_cnt <= pwm_cnt + PWM_W'(1);
         if (pwm_cnt == MAX) begin
            lat_r <= duty_r;
            lat_g <= duty_g;
            lat_b <= duty_b;
         end
         led_r <= ~on_r;
         led_g <= ~on_g;
         led_b <= ~on_b;

         case (state)
            IDLE: begin
               pre <= '0;
               if (!at_goal) begin
                  state <= FADE;
                  busy  <= 1'b1;
               end
            end
            FADE: begin
               // Target changes mid-fade just redirect the ramp; pre keeps running.
               if (tick) begin
                  pre    <= '0;
                  duty_r <= nxt_r;
                  duty_g <= nxt_g;
                  duty_b <= nxt_b;
                  if (nxt_at_goal) begin
                     state <= IDLE;
                     busy  <= 1'b0;
                  end
               end else begin
                  pre <= pre + PRE_W'(1);
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ngv_rgb_fader.sv
// tb_ngv_rgb_fader: directed bench for ngv_rgb_fader (PWM_W=4, STEP_DIV=4),
// plus a slow instance (STEP_DIV=256) that holds each duty long enough to
// inspect whole PWM periods.
module tb_ngv_rgb_fader;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic sel_r_n = 1'b1, sel_g_n = 1'b1, sel_b_n = 1'b1;
   logic led_r, led_g, led_b, busy;
   logic sel_s_r_n = 1'b1;
   logic led_s_r, led_s_g, led_s_b, busy_s;

   int n_tests = 0;
   int n_fail  = 0;
   logic [3:0] m_cnt;   // expected pwm_cnt, free-running from reset

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (rst) m_cnt <= 4'd0;
      else     m_cnt <= m_cnt + 4'd1;
   end

   ngv_rgb_fader #(.PWM_W(4), .STEP_DIV(4)) u_dut (
      .clk(clk), .rst(rst),
      .sel_r_n(sel_r_n), .sel_g_n(sel_g_n), .sel_b_n(sel_b_n),
      .led_r(led_r), .led_g(led_g), .led_b(led_b), .busy(busy)
   );

   ngv_rgb_fader #(.PWM_W(4), .STEP_DIV(256)) u_slow (
      .clk(clk), .rst(rst),
      .sel_r_n(sel_s_r_n), .sel_g_n(1'b1), .sel_b_n(1'b1),
      .led_r(led_s_r), .led_g(led_s_g), .led_b(led_s_b), .busy(busy_s)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick_sample();
      @(posedge clk);
      #1;
   endtask

   // Counts low cycles per LED over a window.
   task automatic count_low(input int cycles, output int lr, output int lg, output int lb);
      lr = 0; lg = 0; lb = 0;
      for (int i = 0; i < cycles; i++) begin
         tick_sample();
         if (!led_r) lr++;
         if (!led_g) lg++;
         if (!led_b) lb++;
      end
   endtask

   // One slow-instance red PWM period, bit i = LED during pwm_cnt==i compare.
   task automatic measure(output logic [15:0] pat);
      int guard;
      guard = 0;
      tick_sample();
      while (m_cnt != 4'd0 && guard < 20) begin
         tick_sample();
         guard++;
      end
      for (int i = 0; i < 16; i++) begin
         tick_sample();
         pat[i] = led_s_r;
      end
   endtask

   initial begin
      int n, lr, lg, lb, bz;
      logic [15:0] pat;

      // 1: reset
      for (int i = 0; i < 3; i++) begin
         tick_sample();
         check("rst_leds", {led_b, led_g, led_r}, 3'b111);
         check("rst_busy", busy, 1'b0);
      end
      @(negedge clk) rst = 1'b0;
      bz = 0;
      count_low(6, lr, lg, lb);
      check("post_rst_leds", lr + lg + lb, 0);
      check("post_rst_busy", busy, 1'b0);

      // 2: fade up to red
      @(negedge clk) sel_r_n = 1'b0;
      tick_sample(); check("red_busy_e1", busy, 1'b0);
      tick_sample(); check("red_busy_e2", busy, 1'b0);
      tick_sample(); check("red_busy_e3", busy, 1'b1);
      n = 0;
      while (busy && n < 200) begin
         tick_sample();
         n++;
         if (n % 4 == 0 && n <= 60) check("red_duty", u_dut.duty_r, n / 4);
      end
      check("red_fade_len", n, 60);
      count_low(20, lr, lg, lb);
      count_low(32, lr, lg, lb);
      check("red_led_r_low", lr, 32);
      check("red_led_g_low", lg, 0);
      check("red_led_b_low", lb, 0);

      // 3: crossfade red -> green
      @(negedge clk) begin sel_r_n = 1'b1; sel_g_n = 1'b0; end
      repeat (3) tick_sample();
      check("xf_busy", busy, 1'b1);
      n = 0;
      while (busy && n < 200) begin
         tick_sample();
         n++;
         check("xf_sum", u_dut.duty_r + u_dut.duty_g, 15);
         if (n % 4 == 0 && n <= 60) check("xf_duty_g", u_dut.duty_g, n / 4);
      end
      check("xf_fade_len", n, 60);
      count_low(20, lr, lg, lb);
      count_low(32, lr, lg, lb);
      check("xf_led_r_low", lr, 0);
      check("xf_led_g_low", lg, 32);
      check("xf_led_b_low", lb, 0);

      // 5: double select holds target, then all off
      @(negedge clk) sel_r_n = 1'b0;
      for (int i = 0; i < 12; i++) begin
         tick_sample();
         if (busy) bz++;
      end
      check("multi_no_busy", bz, 0);
      check("multi_duty_g", u_dut.duty_g, 15);
      @(negedge clk) begin sel_r_n = 1'b1; sel_g_n = 1'b1; end
      repeat (3) tick_sample();
      check("off_busy", busy, 1'b1);
      n = 0;
      while (busy && n < 200) begin
         tick_sample();
         n++;
         if (n % 4 == 0 && n <= 60) check("off_duty_g", u_dut.duty_g, 15 - n / 4);
      end
      check("off_fade_len", n, 60);
      count_low(20, lr, lg, lb);
      count_low(32, lr, lg, lb);
      check("off_leds_low", lr + lg + lb, 0);

      // 6: reset mid-fade
      @(negedge clk) sel_r_n = 1'b0;
      repeat (3 + 28) tick_sample();
      check("mid_duty_r", u_dut.duty_r, 7);
      @(negedge clk) rst = 1'b1;
      tick_sample();
      check("midrst_leds", {led_b, led_g, led_r}, 3'b111);
      check("midrst_busy", busy, 1'b0);
      check("midrst_duty", u_dut.duty_r, 0);
      @(negedge clk) rst = 1'b0;
      tick_sample(); check("restart_e1", busy, 1'b0);
      tick_sample(); check("restart_e2", busy, 1'b0);
      tick_sample(); check("restart_e3", busy, 1'b1);
      repeat (4) tick_sample();
      check("restart_duty", u_dut.duty_r, 1);

      // 4: PWM shape on the slow instance
      measure(pat);
      check("pwm_duty0", pat, 16'hFFFF);
      @(negedge clk) sel_s_r_n = 1'b0;
      repeat (3 + 5 * 256 + 40) tick_sample();
      check("slow_duty", u_slow.duty_r, 5);
      measure(pat);
      check("pwm_duty5_a", pat, 16'hFFE0);
      measure(pat);
      check("pwm_duty5_b", pat, 16'hFFE0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
